// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - feeds im2col featuremap and kernel weights through one conv_pe
// and stores every flagged result; a zero priming beat precedes the first window.
module conv_pe_sequencer #(
  parameter int KERNEL_SIZE = 9,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [CNT_W-1:0]  num_windows,
  input  logic [ADDR_W-1:0] fm_base,
  input  logic [15:0]       bias_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fm_addr,
  input  logic [15:0]       fm_rdata,
  output logic [ADDR_W-1:0] wt_addr,
  input  logic [15:0]       wt_rdata,
  output logic              pe_start,
  output logic              pe_ready_in,
  output logic [15:0]       pe_fmap,
  output logic [15:0]       pe_weight,
  output logic [15:0]       pe_bias,
  input  logic [15:0]       pe_result,
  input  logic              pe_flag,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [15:0]       res_wdata
);
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] WT_LAST = ADDR_W'(KERNEL_SIZE - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, win_q;
  logic [ADDR_W-1:0] fm_addr_q, wt_addr_q, res_cnt_q;
  logic [15:0]       bias_q;
  logic              accept, beat, win_end, last_beat, capture;

  assign accept    = (state_q == IDLE) && go;
  assign beat      = (state_q == PRIME) || (state_q == STREAM);
  // On a window's last data beat the issued weight address has already wrapped to tap 0.
  assign win_end   = (state_q == STREAM) && (wt_addr_q == '0);
  assign last_beat = win_end && (win_q == num_q - CNT_W'(1));
  assign capture   = pe_flag && ((state_q == STREAM) || (state_q == DRAIN));

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    pe_start    = 1'b0;
    pe_ready_in = 1'b0;
    pe_fmap     = '0;
    pe_weight   = '0;
    case (state_q)
      IDLE: begin
        if (go) state_d = (num_windows != '0) ? PRIME : DONE;
      end
      PRIME: begin
        busy        = 1'b1;
        pe_start    = 1'b1;
        pe_ready_in = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        busy        = 1'b1;
        pe_start    = 1'b1;
        pe_ready_in = 1'b1;
        pe_fmap     = fm_rdata;
        pe_weight   = wt_rdata;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy        = 1'b1;
        pe_start    = 1'b1;
        pe_ready_in = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      num_q     <= '0;
      win_q     <= '0;
      fm_addr_q <= '0;
      wt_addr_q <= '0;
      res_cnt_q <= '0;
      bias_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        num_q     <= num_windows;
        bias_q    <= bias_in;
        fm_addr_q <= fm_base;
        wt_addr_q <= '0;
        win_q     <= '0;
        res_cnt_q <= '0;
      end else begin
        if (beat) begin
          fm_addr_q <= fm_addr_q + ADDR_W'(1);
          wt_addr_q <= (wt_addr_q == WT_LAST) ? '0 : wt_addr_q + ADDR_W'(1);
          if (win_end) win_q <= win_q + CNT_W'(1);
        end
        if (capture) res_cnt_q <= res_cnt_q + ADDR_W'(1);
      end
    end
  end

  assign fm_addr   = fm_addr_q;
  assign wt_addr   = wt_addr_q;
  assign pe_bias   = bias_q;
  assign res_we    = capture;
  assign res_addr  = res_cnt_q;
  assign res_wdata = capture ? pe_result : '0;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - scoreboard bench for conv_pe_sequencer with a behavioural conv_pe
// and synchronous featuremap/weight RAMs.
module tb_conv_pe_sequencer;
  localparam int K  = 3;
  localparam int AW = 10;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [CW-1:0] num_windows;
  logic [AW-1:0] fm_base;
  logic [15:0]   bias_in;
  logic          busy, done;
  logic [AW-1:0] fm_addr, wt_addr;
  logic [15:0]   fm_rdata, wt_rdata;
  logic          pe_start, pe_ready_in;
  logic [15:0]   pe_fmap, pe_weight, pe_bias, pe_result;
  logic          pe_flag;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [15:0]   res_wdata;

  always #5 clk = ~clk;

  conv_pe_sequencer #(.KERNEL_SIZE(K), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .go(go), .num_windows(num_windows), .fm_base(fm_base),
    .bias_in(bias_in), .busy(busy), .done(done), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .wt_addr(wt_addr), .wt_rdata(wt_rdata), .pe_start(pe_start), .pe_ready_in(pe_ready_in),
    .pe_fmap(pe_fmap), .pe_weight(pe_weight), .pe_bias(pe_bias), .pe_result(pe_result),
    .pe_flag(pe_flag), .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  logic [15:0] fm_mem [0:1023];
  logic [15:0] wt_mem [0:1023];

  always @(posedge clk) begin
    fm_rdata <= fm_mem[fm_addr];
    wt_rdata <= wt_mem[wt_addr];
  end

  // conv_pe model: Q6.10 products; the first window after start absorbs one extra beat.
  logic signed [31:0] pf, pw, pb, prod, pe_acc;
  int                 pe_cnt;
  logic               pe_first, pe_flag_q, flag_inj;
  logic [15:0]        pe_res_q;

  assign pf   = $signed(pe_fmap);
  assign pw   = $signed(pe_weight);
  assign pb   = $signed(pe_bias);
  assign prod = (pf * pw) >>> 10;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_acc <= 0; pe_cnt <= 0; pe_first <= 1'b1; pe_flag_q <= 1'b0; pe_res_q <= '0;
    end else begin
      pe_flag_q <= 1'b0;
      if (!pe_start) begin
        pe_acc <= 0; pe_cnt <= 0; pe_first <= 1'b1;
      end else if (pe_ready_in) begin
        if (pe_cnt == (pe_first ? K : K - 1)) begin
          pe_res_q  <= 16'(pe_acc + prod + pb);
          pe_flag_q <= 1'b1;
          pe_acc    <= 0;
          pe_cnt    <= 0;
          pe_first  <= 1'b0;
        end else begin
          pe_acc <= pe_acc + prod;
          pe_cnt <= pe_cnt + 1;
        end
      end
    end
  end

  assign pe_result = pe_res_q;
  assign pe_flag   = pe_flag_q | flag_inj;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   go_cyc = 0;
  int   dones, writes, ready_cnt, start_cnt;
  int   hist [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (done) dones++;
      if (pe_ready_in) ready_cnt++;
      if (pe_start) start_cnt++;
      if (res_we) begin
        writes++;
        if (sbq.size() == 0) begin
          check_val("unexpected_write", 32'(res_we), 32'd0);
        end else begin
          e = sbq.pop_front();
          check_val("res_addr", 32'(res_addr), 32'(e.addr));
          check_val("res_wdata", 32'(res_wdata), 32'(e.data));
          check_val("res_lat", 32'(cyc - go_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  function automatic logic [15:0] exp_res(input int base, input int w, input int bias);
    logic signed [31:0] s, f, q;
    logic [AW-1:0]      a;
    s = 0;
    for (int k = 0; k < K; k++) begin
      a = AW'(base + w * K + k);
      f = $signed(fm_mem[a]);
      q = $signed(wt_mem[k]);
      s = s + ((f * q) >>> 10);
    end
    return 16'(s + bias);
  endfunction

  task automatic run_job(input int n, input int base, input int bias, input string tag,
                         input int glitch);
    int t;
    exp_t x;
    @(posedge clk); #1;
    dones = 0; writes = 0; ready_cnt = 0; start_cnt = 0;
    num_windows = CW'(n);
    fm_base     = AW'(base);
    bias_in     = 16'(bias);
    go          = 1'b1;
    for (int w = 0; w < n; w++) begin
      x.addr = AW'(w);
      x.data = exp_res(base, w, bias);
      x.lat  = 2 + (w + 1) * K;
      sbq.push_back(x);
    end
    @(posedge clk); #1;
    go     = 1'b0;
    go_cyc = cyc;
    t      = 0;
    while (!done && t < 200) begin
      if (t < 4) hist[t] = int'(fm_addr);
      if (t == glitch) begin
        go = 1'b1; num_windows = CW'(5); fm_base = AW'(500);
      end else if (t == glitch + 1) begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
    check_val({tag, "_done_lat"}, 32'(cyc - go_cyc + 1), 32'((n == 0) ? 1 : n * K + 3));
    check_val({tag, "_start_in_done"}, 32'(pe_start), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_done_count"}, 32'(dones), 32'd1);
    check_val({tag, "_write_count"}, 32'(writes), 32'(n));
    check_val({tag, "_sb_left"}, 32'(sbq.size()), 32'd0);
    check_val({tag, "_ready_cycles"}, 32'(ready_cnt), 32'((n == 0) ? 0 : n * K + 2));
    check_val({tag, "_start_cycles"}, 32'(start_cnt), 32'((n == 0) ? 0 : n * K + 2));
    sbq.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_ctl"}, {27'd0, busy, done, pe_start, pe_ready_in, res_we}, 32'd0);
    check_val({tag, "_addrs"}, {12'd0, fm_addr, wt_addr}, 32'd0);
    check_val({tag, "_pe_data"}, {pe_fmap, pe_weight}, 32'd0);
    check_val({tag, "_bias_res"}, {pe_bias, res_wdata}, 32'd0);
    check_val({tag, "_res_addr"}, 32'(res_addr), 32'd0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; flag_inj = 1'b0;
    num_windows = '0; fm_base = '0; bias_in = '0;
    for (int i = 0; i < 1024; i++) begin
      fm_mem[i] = '0;
      wt_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // single window, all ones in Q6.10
    for (int i = 0; i < 3; i++) begin
      fm_mem[i] = 16'd1024;
      wt_mem[i] = 16'd1024;
    end
    run_job(1, 0, 0, "single", -1);

    // two windows back to back
    fm_mem[8]  = 16'd1024; fm_mem[9]  = 16'd2048; fm_mem[10] = 16'd0;
    fm_mem[11] = 16'd1024; fm_mem[12] = 16'd1024; fm_mem[13] = 16'd1024;
    run_job(2, 8, 16, "two_win", -1);

    // featuremap address wraps past the top of the buffer
    fm_mem[1022] = 16'd512; fm_mem[1023] = 16'hFC00; fm_mem[0] = 16'd3000;
    wt_mem[0] = 16'd2048; wt_mem[1] = 16'd1024; wt_mem[2] = 16'hFE00;
    run_job(1, 1022, 5, "wrap", -1);
    check_val("wrap_addr0", 32'(hist[0]), 32'd1022);
    check_val("wrap_addr1", 32'(hist[1]), 32'd1023);
    check_val("wrap_addr2", 32'(hist[2]), 32'd0);

    run_job(0, 5, 7, "zero", -1);

    // a flag while idle must never reach the result buffer
    writes = 0;
    flag_inj = 1'b1;
    @(posedge clk); #1;
    check_val("idle_flag_we", 32'(res_we), 32'd0);
    @(posedge clk); #1;
    flag_inj = 1'b0;
    check_val("idle_flag_writes", 32'(writes), 32'd0);

    for (int i = 0; i < 1024; i++) fm_mem[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < K; i++) wt_mem[i] = 16'($urandom_range(0, 65535));
    run_job(2, 40, 300, "go_busy", 2);
    run_job(4, 700, -100, "random4", -1);

    // reset in the middle of streaming, then a clean job
    @(posedge clk); #1;
    num_windows = CW'(2); fm_base = AW'(100); bias_in = 16'd77; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(3, 200, -100, "post_reset", -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
